// File: rtl/cam_align_pkg.sv
// rtl/cam_align_pkg.sv - shared lane geometry and lane FSM state for the LVDS word aligner
package cam_align_pkg;

   localparam int LANES     = 5;
   localparam int LANE_W    = 8;
   localparam int SYNC_LANE = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOCK,
      S_CHECK,
      S_SLIP,
      S_SETTLE,
      S_DONE,
      S_FAILED
   } lane_state_t;

   function automatic logic state_busy(input lane_state_t s);
      return s inside {S_WAIT_LOCK, S_CHECK, S_SLIP, S_SETTLE};
   endfunction

endpackage

// File: rtl/cam_lane_align.sv
// rtl/cam_lane_align.sv - one lane: registered compare, match/slip/settle counters, bitslip pulse
module cam_lane_align
   import cam_align_pkg::*;
#(
   parameter logic [LANE_W-1:0] TRAIN_WORD    = 8'h3A,
   parameter int                MATCH_COUNT   = 16,
   parameter int                SETTLE_CYCLES = 4,
   parameter int                MAX_SLIPS     = 8
) (
   input  logic              c,
   input  logic              rst_n,
   input  logic [LANE_W-1:0] word,
   input  logic              locked,
   input  logic              locked_q,
   input  logic              start,
   output logic              bitslip,
   output logic              done,
   output logic              failed,
   output logic              busy
);

   localparam int MW = $clog2(MATCH_COUNT + 1);
   localparam int SW = $clog2(MAX_SLIPS + 1);
   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [MW-1:0] MATCH_MAX   = MW'(MATCH_COUNT);
   localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
   localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIPS);
   localparam logic [SW-1:0] SLIP_LAST   = SW'(MAX_SLIPS - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

   lane_state_t       state, state_d;
   logic [LANE_W-1:0] word_q;
   logic [MW-1:0]     match_cnt, match_d;
   logic [SW-1:0]     slip_cnt, slip_d;
   logic [TW-1:0]     settle_cnt, settle_d;

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         word_q     <= '0;
         match_cnt  <= '0;
         slip_cnt   <= '0;
         settle_cnt <= '0;
         bitslip    <= 1'b0;
      end else begin
         state      <= state_d;
         word_q     <= word;
         match_cnt  <= match_d;
         slip_cnt   <= slip_d;
         settle_cnt <= settle_d;
         bitslip    <= (state_d == S_SLIP);
      end
   end

   // Lock loss keeps the slip count: the deserializer retains its slip position.
   always_comb begin
      state_d  = state;
      match_d  = match_cnt;
      slip_d   = slip_cnt;
      settle_d = settle_cnt;
      if (start) begin
         state_d  = S_WAIT_LOCK;
         match_d  = '0;
         slip_d   = '0;
         settle_d = '0;
      end else if (!locked && state != S_IDLE) begin
         state_d  = S_WAIT_LOCK;
         match_d  = '0;
         settle_d = '0;
      end else begin
         case (state)
            S_WAIT_LOCK: begin
               if (locked_q) state_d = S_CHECK;
            end
            S_CHECK: begin
               if (word_q == TRAIN_WORD) begin
                  if (match_cnt != MATCH_MAX) match_d = match_cnt + 1'b1;
                  if (match_cnt >= MATCH_LAST) state_d = S_DONE;
               end else begin
                  match_d = '0;
                  state_d = S_SLIP;
               end
            end
            S_SLIP: begin
               if (slip_cnt != SLIP_MAX) slip_d = slip_cnt + 1'b1;
               settle_d = '0;
               state_d  = (slip_cnt >= SLIP_LAST) ? S_FAILED : S_SETTLE;
            end
            S_SETTLE: begin
               if (settle_cnt >= SETTLE_LAST) state_d = S_CHECK;
               else settle_d = settle_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done   = (state == S_DONE);
   assign failed = (state == S_FAILED);
   assign busy   = state_busy(state);

endmodule

// File: rtl/cam_lvds_align.sv
// rtl/cam_lvds_align.sv - per-camera bitslip controller: five lane aligners plus registered status
module cam_lvds_align
   import cam_align_pkg::*;
#(
   parameter logic [LANE_W-1:0] TRAIN_WORD    = 8'h3A,
   parameter int                MATCH_COUNT   = 16,
   parameter int                SETTLE_CYCLES = 4,
   parameter int                MAX_SLIPS     = 8
) (
   input  logic                     c,
   input  logic                     rst_n,
   input  logic [LANES*LANE_W-1:0]  rxd,
   input  logic                     rx_locked,
   input  logic                     start,
   output logic [LANES-1:0]         bitslip,
   output logic [LANES-1:0]         lane_aligned,
   output logic                     aligned,
   output logic                     fail,
   output logic                     busy
);

   logic             locked_q;
   logic [LANES-1:0] lane_done;
   logic [LANES-1:0] lane_failed;
   logic [LANES-1:0] lane_busy;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      cam_lane_align #(
         .TRAIN_WORD    (TRAIN_WORD),
         .MATCH_COUNT   (MATCH_COUNT),
         .SETTLE_CYCLES (SETTLE_CYCLES),
         .MAX_SLIPS     (MAX_SLIPS)
      ) u_lane (
         .c        (c),
         .rst_n    (rst_n),
         .word     (rxd[k*LANE_W +: LANE_W]),
         .locked   (rx_locked),
         .locked_q (locked_q),
         .start    (start),
         .bitslip  (bitslip[k]),
         .done     (lane_done[k]),
         .failed   (lane_failed[k]),
         .busy     (lane_busy[k])
      );
   end

   // fail is sticky until the next start; start wins over a lane still reported FAILED.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         locked_q     <= 1'b0;
         lane_aligned <= '0;
         aligned      <= 1'b0;
         fail         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         locked_q     <= rx_locked;
         lane_aligned <= lane_done;
         aligned      <= &lane_aligned;
         busy         <= |lane_busy;
         if (start) fail <= 1'b0;
         else if (|lane_failed) fail <= 1'b1;
      end
   end

endmodule
